// File: rtl/calc_entry_ctrl.sv
// Numpad-to-ALU sequencer: assembles two hex operands from key events,
// issues the chosen operation over a valid/ready handshake, waits for the
// result and drives the display and error indicator.
module calc_entry_ctrl #(
   parameter int WIDTH   = 16,
   parameter int DIGITS  = WIDTH / 4,
   parameter int TIMEOUT = 1023
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       key_value,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   output logic             alu_valid,
   input  logic             alu_ready,
   input  logic             alu_done,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_error,
   output logic [WIDTH-1:0] display,
   output logic             error_led,
   output logic             busy
);
   localparam int CW = $clog2(DIGITS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DIGITS);
   localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {ST_ENTER_A, ST_ENTER_B, ST_ISSUE, ST_WAIT, ST_SHOW} state_t;
   typedef enum logic [2:0] {KEY_NONE, KEY_DIGIT, KEY_OP, KEY_CLEAR, KEY_BKSP, KEY_EQUALS} key_kind_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, result_q, result_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       op_q, op_d, pend_op_q, pend_op_d;
   logic             pend_valid_q, pend_valid_d, err_q, err_d;
   logic [TW-1:0]    timer_q, timer_d;

   key_kind_t        key_kind;
   logic [3:0]       key_digit;
   logic [2:0]       key_code;
   logic             do_clear;

   // Classify the raw numpad event into digit / operation / command.
   // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      key_kind  = KEY_NONE;
      key_digit = 4'h0;
      key_code  = 3'd0;
      if (key_value[5]) begin
         if (key_value[4]) begin
            key_kind = KEY_DIGIT;
            case (key_value[3:0])
               4'd0:  key_digit = 4'h1;
               4'd1:  key_digit = 4'h4;
               4'd2:  key_digit = 4'h7;
               4'd3:  key_digit = 4'h0;
               4'd4:  key_digit = 4'h2;
               4'd5:  key_digit = 4'h5;
               4'd6:  key_digit = 4'h8;
               4'd7:  key_digit = 4'hF;
               4'd8:  key_digit = 4'h3;
               4'd9:  key_digit = 4'h6;
               4'd10: key_digit = 4'h9;
               4'd11: key_digit = 4'hE;
               4'd12: key_digit = 4'hA;
               4'd13: key_digit = 4'hB;
               4'd14: key_digit = 4'hC;
               4'd15: key_digit = 4'hD;
            endcase
         end else begin
            case (key_value[3:0])
               4'd0:    begin key_kind = KEY_OP; key_code = 3'd0; end
               4'd4:    begin key_kind = KEY_OP; key_code = 3'd1; end
               4'd8:    begin key_kind = KEY_OP; key_code = 3'd2; end
               4'd12:   begin key_kind = KEY_OP; key_code = 3'd3; end
               4'd1:    begin key_kind = KEY_OP; key_code = 3'd4; end
               4'd5:    begin key_kind = KEY_OP; key_code = 3'd5; end
               4'd9:    begin key_kind = KEY_OP; key_code = 3'd6; end
               4'd13:   begin key_kind = KEY_OP; key_code = 3'd7; end
               4'd3:    key_kind = KEY_CLEAR;
               4'd7:    key_kind = KEY_BKSP;
               4'd11:   key_kind = KEY_EQUALS;
               default: key_kind = KEY_NONE;
            endcase
         end
      end
   end

   // Next-state and register update rules for entry, issue, wait and show.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      pend_op_d    = pend_op_q;
      pend_valid_d = pend_valid_q;
      result_d     = result_q;
      err_d        = err_q;
      timer_d      = '0;
      do_clear     = 1'b0;

      case (state_q)
         ST_ENTER_A, ST_ENTER_B: begin
            case (key_kind)
               KEY_DIGIT: begin
                  if (cnt_q != CNT_FULL) begin
                     acc_d = {acc_q[WIDTH-5:0], key_digit};
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               KEY_BKSP: begin
                  acc_d = acc_q >> 4;
                  if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
               end
               KEY_CLEAR: do_clear = 1'b1;
               KEY_OP: begin
                  if (state_q == ST_ENTER_A) begin
                     a_d     = acc_q;
                     op_d    = key_code;
                     acc_d   = '0;
                     cnt_d   = '0;
                     state_d = ST_ENTER_B;
                  end else if (cnt_q == '0) begin
                     op_d = key_code;
                  end else begin
                     // Chained operation: remember the new operator for after the result.
                     b_d          = acc_q;
                     pend_op_d    = key_code;
                     pend_valid_d = 1'b1;
                     acc_d        = '0;
                     cnt_d        = '0;
                     state_d      = ST_ISSUE;
                  end
               end
               KEY_EQUALS: begin
                  if (state_q == ST_ENTER_B && cnt_q != '0) begin
                     b_d          = acc_q;
                     pend_valid_d = 1'b0;
                     acc_d        = '0;
                     cnt_d        = '0;
                     state_d      = ST_ISSUE;
                  end
               end
               default: ;
            endcase
         end
         ST_ISSUE: begin
            if (alu_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (alu_done || timer_q == TIMER_END) begin
               // A result arriving on the expiry cycle takes precedence over the timeout.
               if (alu_done) begin
                  result_d = alu_result;
                  err_d    = alu_error;
               end else begin
                  result_d = '0;
                  err_d    = 1'b1;
               end
               if (!alu_done || alu_error || !pend_valid_q) begin
                  pend_valid_d = 1'b0;
                  state_d      = ST_SHOW;
               end else begin
                  a_d          = alu_result;
                  op_d         = pend_op_q;
                  pend_valid_d = 1'b0;
                  acc_d        = '0;
                  cnt_d        = '0;
                  state_d      = ST_ENTER_B;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_SHOW: begin
            case (key_kind)
               KEY_DIGIT: begin
                  acc_d   = {{(WIDTH-4){1'b0}}, key_digit};
                  cnt_d   = CW'(1);
                  err_d   = 1'b0;
                  state_d = ST_ENTER_A;
               end
               KEY_OP: begin
                  if (!err_q) begin
                     a_d     = result_q;
                     op_d    = key_code;
                     acc_d   = '0;
                     cnt_d   = '0;
                     state_d = ST_ENTER_B;
                  end
               end
               KEY_EQUALS: begin
                  if (!err_q) begin
                     a_d     = result_q;
                     state_d = ST_ISSUE;
                  end
               end
               KEY_CLEAR: do_clear = 1'b1;
               default: ;
            endcase
         end
         default: state_d = ST_ENTER_A;
      endcase

      if (do_clear) begin
         state_d      = ST_ENTER_A;
         acc_d        = '0;
         cnt_d        = '0;
         a_d          = '0;
         b_d          = '0;
         op_d         = '0;
         pend_op_d    = '0;
         pend_valid_d = 1'b0;
         result_d     = '0;
         err_d        = 1'b0;
      end
   end

   // State and datapath registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_ENTER_A;
         acc_q        <= '0;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         pend_op_q    <= '0;
         pend_valid_q <= 1'b0;
         result_q     <= '0;
         err_q        <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         pend_op_q    <= pend_op_d;
         pend_valid_q <= pend_valid_d;
         result_q     <= result_d;
         err_q        <= err_d;
         timer_q      <= timer_d;
      end
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      display = acc_q;
      case (state_q)
         ST_ENTER_B:        display = (cnt_q == '0) ? a_q : acc_q;
         ST_ISSUE, ST_WAIT: display = a_q;
         ST_SHOW:           display = result_q;
         default:           display = acc_q;
      endcase
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign alu_valid = (state_q == ST_ISSUE);
   assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign error_led = err_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: directed scenarios plus random
// key streams compared against a digit-queue reference model, with the
// bench acting as the ALU.
module tb_calc_entry_ctrl;
   localparam int WIDTH   = 16;
   localparam int DIGITS  = WIDTH / 4;
   localparam int TIMEOUT = 1023;

   localparam logic [5:0] K_ADD = 6'h20, K_SUB = 6'h24, K_MUL = 6'h28;
   localparam logic [5:0] K_CLR = 6'h23, K_BS = 6'h27, K_EQ = 6'h2B;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [5:0]       key_value = '0;
   logic             alu_ready = 1'b0, alu_done = 1'b0, alu_error = 1'b0;
   logic [WIDTH-1:0] alu_result = '0;
   logic [WIDTH-1:0] alu_a, alu_b, display;
   logic [2:0]       alu_op;
   logic             alu_valid, error_led, busy;

   calc_entry_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .key_value(key_value),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid(alu_valid),
      .alu_ready(alu_ready), .alu_done(alu_done), .alu_result(alu_result),
      .alu_error(alu_error), .display(display), .error_led(error_led), .busy(busy)
   );

   always #10 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] prim_digit [16] = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                                   4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};
   logic [3:0] op_idx [8] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13};

   // Reference model: operand being typed is a queue of hex digits.
   typedef enum {M_FIRST, M_SECOND, M_SHOW} mode_t;
   mode_t            m_mode;
   logic [3:0]       m_q[$];
   logic [WIDTH-1:0] m_a, m_b, m_res;
   logic [2:0]       m_op, m_pend_op;
   bit               m_pend, m_err, m_issue;

   // Knobs for the bench-side ALU.
   int k_stall = 0, k_lat = 0;
   bit k_ready_pre = 0, k_no_done = 0, k_auto = 1, k_rand_err = 0;

   function automatic logic [5:0] dig(input logic [3:0] d);
      logic [5:0] kv = 6'h30;
      for (int i = 0; i < 16; i++)
         if (prim_digit[i] == d) kv = {2'b11, 4'(i)};
      return kv;
   endfunction

   function automatic logic [WIDTH-1:0] entered();
      logic [WIDTH-1:0] v = '0;
      foreach (m_q[i]) v = (v << 4) | WIDTH'(m_q[i]);
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] exp_display();
      if (m_mode == M_SHOW) return m_res;
      if (m_mode == M_SECOND && m_q.size() == 0) return m_a;
      return entered();
   endfunction

   function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a * b;
         3'd3: return (b == '0) ? '0 : a / b;
         3'd4: return a & b;
         3'd5: return a | b;
         3'd6: return a ^ b;
         default: return a << b[3:0];
      endcase
   endfunction

   task automatic model_reset();
      m_mode = M_FIRST; m_q.delete();
      m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_pend_op = '0;
      m_pend = 0; m_err = 0; m_issue = 0;
   endtask

   // kind: 0 none, 1 digit, 2 op, 3 clear, 4 backspace, 5 equals
   task automatic model_key(input logic [5:0] kv);
      int kind = 0;
      logic [3:0] d = '0;
      logic [2:0] c = '0;
      m_issue = 0;
      if (kv[5]) begin
         if (kv[4]) begin
            kind = 1; d = prim_digit[kv[3:0]];
         end else begin
            for (int i = 0; i < 8; i++) if (op_idx[i] == kv[3:0]) begin kind = 2; c = 3'(i); end
            if (kv[3:0] == 4'd3)  kind = 3;
            if (kv[3:0] == 4'd7)  kind = 4;
            if (kv[3:0] == 4'd11) kind = 5;
         end
      end
      if (kind == 3) begin
         model_reset();
      end else if (m_mode == M_SHOW) begin
         if (kind == 1) begin
            m_q.delete(); m_q.push_back(d); m_err = 0; m_mode = M_FIRST;
         end else if (kind == 2 && !m_err) begin
            m_a = m_res; m_op = c; m_q.delete(); m_mode = M_SECOND;
         end else if (kind == 5 && !m_err) begin
            m_a = m_res; m_issue = 1;
         end
      end else begin
         if (kind == 1 && m_q.size() < DIGITS) m_q.push_back(d);
         else if (kind == 4 && m_q.size() > 0) void'(m_q.pop_back());
         else if (kind == 2 && m_mode == M_FIRST) begin
            m_a = entered(); m_op = c; m_q.delete(); m_mode = M_SECOND;
         end else if (kind == 2 && m_q.size() == 0) begin
            m_op = c;
         end else if (kind == 2) begin
            m_b = entered(); m_pend_op = c; m_pend = 1; m_q.delete(); m_issue = 1;
         end else if (kind == 5 && m_mode == M_SECOND && m_q.size() > 0) begin
            m_b = entered(); m_pend = 0; m_q.delete(); m_issue = 1;
         end
      end
   endtask

   task automatic model_result(input logic [WIDTH-1:0] r, input bit e);
      m_res = r; m_err = e;
      if (!e && m_pend) begin
         m_a = r; m_op = m_pend_op; m_q.delete(); m_mode = M_SECOND;
      end else begin
         m_mode = M_SHOW;
      end
      m_pend = 0;
   endtask

   task automatic do_reset();
      @(negedge clock); reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      model_reset();
   endtask

   // Play the ALU for one transaction and check the handshake and outcome.
   task automatic serve();
      logic [WIDTH-1:0] r;
      bit e, busy_ok;
      int n = 0;
      while (alu_valid !== 1'b1 && n < 4) begin @(negedge clock); n++; end
      n_checks++;
      if (alu_valid !== 1'b1 || alu_a !== m_a || alu_b !== m_b || alu_op !== m_op || busy !== 1'b1 || display !== m_a) begin
         n_fail++;
         $display("FAIL issue: valid=%b a=%h b=%h op=%0d busy=%b disp=%h, expected valid=1 a=%h b=%h op=%0d busy=1 disp=%h",
                  alu_valid, alu_a, alu_b, alu_op, busy, display, m_a, m_b, m_op, m_a);
      end
      for (int i = 0; i < k_stall; i++) begin
         key_value = (i == 0) ? K_CLR : {1'b1, 5'($urandom)};
         @(negedge clock);
         n_checks++;
         if (alu_valid !== 1'b1 || alu_a !== m_a || alu_b !== m_b || alu_op !== m_op) begin
            n_fail++;
            $display("FAIL stall_hold cycle %0d: valid=%b a=%h b=%h op=%0d, expected 1 %h %h %0d",
                     i, alu_valid, alu_a, alu_b, alu_op, m_a, m_b, m_op);
         end
      end
      key_value = '0;
      alu_ready = 1'b1;
      @(negedge clock);
      if (!k_ready_pre) alu_ready = 1'b0;
      n_checks++;
      if (alu_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL valid_drop: valid=%b busy=%b, expected valid=0 busy=1", alu_valid, busy);
      end
      if (k_no_done) begin
         n = 0;
         while (busy === 1'b1 && n < TIMEOUT + 20) begin @(negedge clock); n++; end
         n_checks++;
         if (busy !== 1'b0 || n < TIMEOUT - 2 || n > TIMEOUT + 2) begin
            n_fail++;
            $display("FAIL timeout_len: busy=%b after %0d cycles, expected busy=0 after about %0d", busy, n, TIMEOUT);
         end
         model_result('0, 1'b1);
      end else begin
         busy_ok = 1;
         for (int i = 0; i < k_lat; i++) begin
            key_value = {1'b1, 5'($urandom)};
            @(negedge clock);
            if (busy !== 1'b1) busy_ok = 0;
         end
         key_value = '0;
         n_checks++;
         if (!busy_ok) begin
            n_fail++;
            $display("FAIL wait_busy: busy=0 during WAIT, expected 1");
         end
         r = ref_alu(m_op, m_a, m_b);
         e = (m_op == 3'd3 && m_b == '0) || (k_rand_err && $urandom_range(0, 15) == 0);
         if (e) r = WIDTH'($urandom);
         alu_done = 1'b1; alu_result = r; alu_error = e;
         @(negedge clock);
         alu_done = 1'b0; alu_result = WIDTH'($urandom); alu_error = 1'b0;
         model_result(r, e);
      end
      n_checks++;
      if (display !== exp_display() || error_led !== m_err || busy !== 1'b0 || alu_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL result: disp=%h err=%b busy=%b valid=%b, expected disp=%h err=%b busy=0 valid=0",
                  display, error_led, busy, alu_valid, exp_display(), m_err);
      end
   endtask

   // Drive one key event for a single cycle and compare against the model.
   task automatic press(input logic [5:0] kv);
      @(negedge clock); key_value = kv;
      @(negedge clock); key_value = '0;
      model_key(kv);
      if (m_issue) begin
         if (k_auto) serve();
      end else begin
         n_checks++;
         if (display !== exp_display() || error_led !== m_err || busy !== 1'b0 || alu_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL key %h: disp=%h err=%b busy=%b valid=%b, expected disp=%h err=%b busy=0 valid=0",
                     kv, display, error_led, busy, alu_valid, exp_display(), m_err);
         end
      end
   endtask

   task automatic set_knobs(input int stall, input int lat, input bit ready_pre);
      k_stall = stall; k_lat = lat; k_ready_pre = ready_pre; k_no_done = 0;
      k_auto = 1; k_rand_err = 0;
      alu_ready = ready_pre;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (alu_valid !== 1'b0 || display !== '0 || error_led !== 1'b0 || busy !== 1'b0 ||
          alu_a !== '0 || alu_b !== '0 || alu_op !== '0) begin
         n_fail++;
         $display("FAIL reset: valid=%b disp=%h err=%b busy=%b a=%h b=%h op=%0d, expected all 0",
                  alu_valid, display, error_led, busy, alu_a, alu_b, alu_op);
      end
   endtask

   task automatic test_digit_entry();
      do_reset(); set_knobs(0, 0, 0);
      press(6'h30); press(6'h34); press(6'h3C);
      n_checks++;
      if (display !== 16'h012A) begin n_fail++; $display("FAIL three_digits: disp=%h, expected 012a", display); end
      repeat (5) press(6'h33);
      n_checks++;
      if (display !== 16'h12A0) begin n_fail++; $display("FAIL digit_limit: disp=%h, expected 12a0", display); end
      press(K_BS);
      press(dig(4'h1));
      n_checks++;
      if (display !== 16'h12A1) begin n_fail++; $display("FAIL backspace_reentry: disp=%h, expected 12a1", display); end
      repeat (5) press(K_BS);
      press(dig(4'h5));
      n_checks++;
      if (display !== 16'h0005) begin n_fail++; $display("FAIL backspace_empty: disp=%h, expected 0005", display); end
      press(K_CLR);
   endtask

   task automatic test_basic_add();
      do_reset(); set_knobs(0, 2, 1);
      press(dig(4'h3)); press(K_ADD); press(dig(4'h4)); press(K_EQ);
      n_checks++;
      if (display !== 16'h0007 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_add: disp=%h busy=%b, expected 0007 0", display, busy);
      end
      alu_ready = 1'b0;
   endtask

   task automatic test_op_replace_repeat();
      do_reset(); set_knobs(1, 1, 0);
      press(dig(4'h5)); press(K_ADD); press(K_SUB); press(dig(4'h2)); press(K_EQ);
      n_checks++;
      if (display !== 16'h0003) begin n_fail++; $display("FAIL op_replace: disp=%h, expected 0003", display); end
      press(K_EQ);
      n_checks++;
      if (display !== 16'h0001) begin n_fail++; $display("FAIL repeat_equals: disp=%h, expected 0001", display); end
   endtask

   task automatic test_chain();
      do_reset(); set_knobs(0, 1, 0);
      press(dig(4'h6)); press(K_MUL); press(dig(4'h2)); press(K_ADD);
      n_checks++;
      if (display !== 16'h000C || alu_op !== 3'd0) begin
         n_fail++; $display("FAIL chain_mid: disp=%h op=%0d, expected 000c 0", display, alu_op);
      end
      press(dig(4'h1)); press(K_EQ);
      n_checks++;
      if (display !== 16'h000D) begin n_fail++; $display("FAIL chain_end: disp=%h, expected 000d", display); end
   endtask

   task automatic test_stall();
      do_reset(); set_knobs(5, 3, 0);
      press(dig(4'h9)); press(K_SUB); press(dig(4'h4)); press(K_EQ);
      n_checks++;
      if (display !== 16'h0005 || error_led !== 1'b0) begin
         n_fail++; $display("FAIL stall_result: disp=%h err=%b, expected 0005 0", display, error_led);
      end
   endtask

   task automatic test_timeout();
      do_reset(); set_knobs(0, 0, 0); k_no_done = 1;
      press(dig(4'h1)); press(K_ADD); press(dig(4'h1)); press(K_EQ);
      k_no_done = 0;
      n_checks++;
      if (display !== '0 || error_led !== 1'b1) begin
         n_fail++; $display("FAIL timeout_err: disp=%h err=%b, expected 0000 1", display, error_led);
      end
      press(K_ADD);
      n_checks++;
      if (error_led !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL op_in_error: err=%b busy=%b, expected 1 0", error_led, busy);
      end
      press(dig(4'h7));
      n_checks++;
      if (display !== 16'h0007 || error_led !== 1'b0) begin
         n_fail++; $display("FAIL error_recover: disp=%h err=%b, expected 0007 0", display, error_led);
      end
   endtask

   task automatic test_reset_mid_op();
      do_reset(); set_knobs(0, 0, 0); k_auto = 0;
      press(dig(4'h2)); press(K_ADD); press(dig(4'h3)); press(K_EQ);
      n_checks++;
      if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_issue: valid=%b, expected 1", alu_valid); end
      reset = 1'b1; @(negedge clock); reset = 1'b0; model_reset();
      n_checks++;
      if (alu_valid !== 1'b0 || busy !== 1'b0 || display !== '0 || error_led !== 1'b0 || alu_a !== '0 || alu_b !== '0) begin
         n_fail++; $display("FAIL reset_in_issue: valid=%b busy=%b disp=%h a=%h b=%h, expected all 0",
                            alu_valid, busy, display, alu_a, alu_b);
      end
      press(dig(4'h2)); press(K_ADD); press(dig(4'h3)); press(K_EQ);
      alu_ready = 1'b1; @(negedge clock); alu_ready = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || alu_valid !== 1'b0) begin
         n_fail++; $display("FAIL enter_wait: busy=%b valid=%b, expected 1 0", busy, alu_valid);
      end
      reset = 1'b1; @(negedge clock); reset = 1'b0; model_reset();
      alu_done = 1'b1; alu_result = 16'h00FF; @(negedge clock); alu_done = 1'b0;
      n_checks++;
      if (alu_valid !== 1'b0 || busy !== 1'b0 || display !== '0 || error_led !== 1'b0 || alu_op !== '0) begin
         n_fail++; $display("FAIL reset_in_wait: valid=%b busy=%b disp=%h err=%b op=%0d, expected all 0",
                            alu_valid, busy, display, error_led, alu_op);
      end
      k_auto = 1;
   endtask

   task automatic test_random();
      int sel;
      logic [5:0] kv;
      do_reset(); set_knobs(0, 0, 0); k_rand_err = 1;
      for (int n = 0; n < 300; n++) begin
         k_stall = $urandom_range(0, 3);
         k_lat   = $urandom_range(0, 4);
         sel = $urandom_range(0, 99);
         if (sel < 50)      kv = {2'b11, 4'($urandom)};
         else if (sel < 68) kv = {2'b10, op_idx[$urandom_range(0, 7)]};
         else if (sel < 80) kv = K_EQ;
         else if (sel < 88) kv = K_BS;
         else if (sel < 91) kv = K_CLR;
         else if (sel < 96) kv = {2'b10, 4'({$urandom_range(0, 2), 2'b10})};
         else               kv = {1'b0, 5'($urandom)};
         press(kv);
      end
      k_rand_err = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      test_reset();
      test_digit_entry();
      test_basic_add();
      test_op_replace_repeat();
      test_chain();
      test_stall();
      test_timeout();
      test_reset_mid_op();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
